// File: rtl/parser_head_gen.sv
// parser_head_gen
// Ingress front-end of the packet parser. It captures the first HEAD_WIDTH
// bits of each packet into a zero-padded header vector and counts the packet
// length. One cycle after the end-of-packet beat it emits a tagged head word
// and a tagged metadata word as a single-cycle valid pulse. There is no
// backpressure.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_data_valid     beat valid
//   i_data_sop       first beat of packet (qualified by valid)
//   i_data_eop       last beat of packet (qualified by valid)
//   i_data_mod       valid bytes in the eop beat, 0 means a full beat
//   i_data           beat data, byte 0 in the top byte lane
//   i_in_port        ingress port, sampled on sop
//   o_head           {tag, head}, packet byte 0 at the top of head
//   o_meta           {tag, meta}: [15:0] length, [23:16] captured bytes, [31:24] port
//   o_err_cnt        saturating count of aborted packets
module parser_head_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int HEAD_WIDTH = 1024,
  parameter int META_WIDTH = 64,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_data_valid,
  input  logic                            i_data_sop,
  input  logic                            i_data_eop,
  input  logic [3:0]                      i_data_mod,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [7:0]                      i_in_port,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic [15:0]                     o_err_cnt
);

  localparam int              NUM_BEATS  = HEAD_WIDTH / DATA_WIDTH;
  localparam int              IDX_W      = $clog2(NUM_BEATS + 1);
  localparam int              SEQ_W      = TAG_WIDTH - 1;
  localparam logic [4:0]      BEAT_BYTES = 5'(DATA_WIDTH / 8);
  localparam logic [15:0]     HEAD_BYTES = 16'(HEAD_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BEATS);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       beat_idx;
  logic [HEAD_WIDTH-1:0]  head_buf;
  logic [15:0]            len_cnt;
  logic [7:0]             port_reg;
  logic [SEQ_W-1:0]       seq_id;

  logic                   start;
  logic                   active;
  logic                   emit;
  logic                   store;
  logic [4:0]             beat_bytes;
  logic [DATA_WIDTH-1:0]  keep_mask;
  logic [DATA_WIDTH-1:0]  beat_data;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       idx_inc;
  logic [16:0]            len_sum;
  logic [15:0]            len_next;
  logic [15:0]            hbytes_wide;
  logic [7:0]             hbytes;
  logic [7:0]             port_next;
  logic [HEAD_WIDTH-1:0]  head_next;

  // Next-state datapath for the beat being presented. A sop always restarts
  // from a cleared buffer and zero length, which also covers the abort case
  // where a new packet begins while another is still open.
  always_comb begin
    start      = i_data_valid & i_data_sop;
    active     = i_data_valid & (i_data_sop | (state != IDLE));
    emit       = active & i_data_eop;
    beat_bytes = BEAT_BYTES;
    if (i_data_eop && (i_data_mod != 4'd0)) beat_bytes = {1'b0, i_data_mod};
    // Keep the top beat_bytes lanes; a full beat shifts everything out.
    keep_mask  = ~({DATA_WIDTH{1'b1}} >> {beat_bytes, 3'b000});
    beat_data  = i_data & keep_mask;
    wr_idx     = start ? '0 : beat_idx;
    idx_inc    = wr_idx + 1'b1;
    store      = start | (i_data_valid & (state == COLLECT));
    head_next  = start ? '0 : head_buf;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (store && (wr_idx == IDX_W'(b)))
        head_next[HEAD_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH] = beat_data;
    end
    len_sum     = {1'b0, (start ? 16'd0 : len_cnt)} + 17'(beat_bytes);
    len_next    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    hbytes_wide = (len_next < HEAD_BYTES) ? len_next : HEAD_BYTES;
    hbytes      = (hbytes_wide > 16'd255) ? 8'hFF : hbytes_wide[7:0];
    port_next   = start ? i_in_port : port_reg;
  end

  // Packet FSM with registered head/meta outputs. Outputs are zero except in
  // the single cycle after an accepted eop beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      beat_idx  <= '0;
      head_buf  <= '0;
      len_cnt   <= '0;
      port_reg  <= '0;
      seq_id    <= '0;
      o_head    <= '0;
      o_meta    <= '0;
      o_err_cnt <= '0;
    end else begin
      o_head <= '0;
      o_meta <= '0;
      if (emit) begin
        o_head <= {1'b1, seq_id, head_next};
        o_meta <= {1'b1, seq_id, {(META_WIDTH-32){1'b0}}, port_next, hbytes, len_next};
        seq_id <= seq_id + 1'b1;
      end
      if (start && (state != IDLE) && (o_err_cnt != 16'hFFFF))
        o_err_cnt <= o_err_cnt + 16'd1;
      if (active) begin
        head_buf <= head_next;
        len_cnt  <= len_next;
        port_reg <= port_next;
        if (i_data_eop) begin
          state    <= IDLE;
          beat_idx <= '0;
        end else if (store) begin
          beat_idx <= idx_inc;
          state    <= (idx_inc == LAST_IDX) ? DRAIN : COLLECT;
        end else begin
          state <= DRAIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_parser_head_gen.sv
// tb_parser_head_gen
// Self-checking bench for parser_head_gen. The driver feeds beats and keeps a
// byte-level packet model; each completed packet pushes its expected head and
// meta words plus the expected emit cycle into a scoreboard queue. A monitor
// on the falling clock edge pops and compares whenever an emit appears, and
// checks idle/reset outputs and the abort counter every cycle.
module tb_parser_head_gen;

  localparam int DW = 128;
  localparam int HW = 1024;
  localparam int MW = 64;
  localparam int TW = 8;
  localparam int HEAD_BYTES = HW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            sop = 1'b0;
  logic            eop = 1'b0;
  logic [3:0]      mod = '0;
  logic [DW-1:0]   data = '0;
  logic [7:0]      port = '0;
  logic [HW+TW-1:0] head;
  logic [MW+TW-1:0] meta;
  logic [15:0]     err_cnt;

  always #5 clk = ~clk;

  parser_head_gen #(
    .DATA_WIDTH(DW), .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(valid), .i_data_sop(sop),
    .i_data_eop(eop), .i_data_mod(mod), .i_data(data), .i_in_port(port),
    .o_head(head), .o_meta(meta), .o_err_cnt(err_cnt)
  );

  typedef struct {
    logic [HW+TW-1:0] head;
    logic [MW+TW-1:0] meta;
    int               cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] err_model = '0;
  logic [15:0] err_committed = '0;
  bit          in_pkt = 1'b0;
  logic [7:0]  pkt_bytes[$];
  int          pkt_len = 0;
  logic [7:0]  pkt_port = '0;
  logic [6:0]  seq_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // The abort counter the DUT should show after each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_committed <= '0;
    else        err_committed <= err_model;
  end

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Packet model: a packet is the list of its bytes; head is its first
  // HEAD_BYTES bytes left-justified, length is the byte count.
  task automatic modelBeat();
    int            nb;
    int            hb;
    exp_t          e;
    logic [HW-1:0] h;
    if (!valid) return;
    if (sop) begin
      if (in_pkt && err_model != 16'hFFFF) err_model++;
      in_pkt = 1'b1;
      pkt_bytes.delete();
      pkt_len = 0;
      pkt_port = port;
    end
    if (!in_pkt) return;
    nb = eop ? ((mod == 4'd0) ? 16 : int'(mod)) : 16;
    for (int i = 0; i < nb; i++)
      if (pkt_bytes.size() < HEAD_BYTES) pkt_bytes.push_back(data[DW-1-8*i -: 8]);
    pkt_len = (pkt_len + nb > 65535) ? 65535 : pkt_len + nb;
    if (eop) begin
      h = '0;
      for (int i = 0; i < pkt_bytes.size(); i++) h[HW-1-8*i -: 8] = pkt_bytes[i];
      hb = (pkt_len < HEAD_BYTES) ? pkt_len : HEAD_BYTES;
      e.head = {1'b1, seq_model, h};
      e.meta = {1'b1, seq_model, 32'h0, pkt_port, 8'(hb), 16'(pkt_len)};
      e.cyc  = cyc + 1;
      sb.push_back(e);
      seq_model++;
      in_pkt = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic e,
                               input logic [3:0] m, input logic [DW-1:0] d,
                               input logic [7:0] p);
    @(posedge clk);
    #1;
    valid = v; sop = s; eop = e; mod = m; data = d; port = p;
    modelBeat();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, rand_data(), 8'd0);
  endtask

  task automatic sendPacket(input int nbeats, input logic [3:0] m, input logic [7:0] p,
                            input bit abort, input bit gaps);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && b != 0 && ($urandom % 4) == 0) idleCycles(1);
      applyStimulus(1'b1, b == 0, (b == nbeats - 1) && !abort, m, rand_data(), p);
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_pending actual=%0d expected=0", sb.size());
    end
    sb.delete();
    in_pkt = 1'b0;
    err_model = '0;
    seq_model = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every emit with the scoreboard head, otherwise expect
  // all-zero outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkOutput("reset_head_any", 512'(|head), 512'(0));
      checkOutput("reset_meta", 512'(meta), 512'(0));
      checkOutput("reset_err_cnt", 512'(err_cnt), 512'(0));
    end else begin
      if (head[HW+TW-1] || meta[MW+TW-1]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_emit actual_tag=%0h required=no emit", head[HW+TW-1 -: TW]);
        end else begin
          e = sb.pop_front();
          checkOutput("head_tag", 512'(head[HW+TW-1 -: TW]), 512'(e.head[HW+TW-1 -: TW]));
          checkOutput("meta_tag", 512'(meta[MW+TW-1 -: TW]), 512'(e.meta[MW+TW-1 -: TW]));
          checkOutput("head_hi", head[HW-1 -: 512], e.head[HW-1 -: 512]);
          checkOutput("head_lo", head[511:0], e.head[511:0]);
          checkOutput("meta", 512'(meta), 512'(e.meta));
          checkOutput("emit_cycle", 512'(cyc), 512'(e.cyc));
        end
      end else begin
        checkOutput("idle_head_any", 512'(|head), 512'(0));
        checkOutput("idle_meta", 512'(meta), 512'(0));
      end
      checkOutput("err_cnt", 512'(err_cnt), 512'(err_committed));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single-beat packet, mod=14, port=3");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd14, rand_data(), 8'd3);
    idleCycles(2);

    $display("[TB] two 4-beat 60-byte packets");
    resetDut();
    sendPacket(4, 4'd12, 8'd7, 1'b0, 1'b0);
    sendPacket(4, 4'd12, 8'd7, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] 10-beat 160-byte packet");
    sendPacket(10, 4'd0, 8'd9, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] abort by new sop");
    resetDut();
    sendPacket(2, 4'd0, 8'd1, 1'b1, 1'b0);
    sendPacket(3, 4'd5, 8'd2, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] 130 back-to-back single-beat packets");
    for (int i = 0; i < 130; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 4'($urandom), rand_data(), 8'($urandom));
    idleCycles(2);

    $display("[TB] reset in the middle of a packet");
    resetDut();
    sendPacket(3, 4'd0, 8'd4, 1'b1, 1'b0);
    resetDut();
    sendPacket(1, 4'd8, 8'd6, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] randomized packets");
    for (int n = 0; n < 150; n++) begin
      if (($urandom % 8) == 0)
        applyStimulus(1'b1, 1'b0, 1'($urandom), 4'($urandom), rand_data(), 8'($urandom));
      if (($urandom % 3) == 0) idleCycles($urandom_range(1, 2));
      sendPacket($urandom_range(1, 12), 4'($urandom), 8'($urandom),
                 ($urandom % 10) == 0, 1'b1);
    end
    idleCycles(5);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_emits actual=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
